brake_seq: RTL
==============

# brake_seq

Brake engage/hold sequencer acting as a single OPB bus master in front of the brake PWM controller. On an engage request it programs polarity, pull-in duty and enable, holds pull-in for a fixed time, then drops to hold duty. While engaged it polls the controller fault register. On a fault or a release request it disables the output, and it clears latched faults on command.

## Interface
- PULL_DUTY, 32'h258: CYCLE register value during pull-in.
- HOLD_DUTY, 32'h12C: CYCLE register value during hold.
- POLARITY, 1'b1: value written to the POL register.
- PULL_TIME, 16'd32000: pull-in duration in OPB_CLK cycles (1 ms at 32 MHz); legal range 1..65535.
- POLL_PERIOD, 16'd320: cycles between fault-register reads; legal range 4..65535.

Ports:
- OPB_CLK  in  1  bus clock (32 MHz); the only clock.
- OPB_RSTb  in  1  reset, synchronous, active-low.
- ENGAGE  in  1  level engage request; synchronous to OPB_CLK.
- CLR_FAULT  in  1  one-cycle fault-clear command.
- M_ADDR  out  4  OPB word address (ENABLE=6, POL=7, CYCLE=8, FAULT=5).
- M_DO  out  32  write data.
- M_WE  out  1  write strobe, one cycle per access.
- M_RE  out  1  read strobe, one cycle per access.
- M_DI  in  32  read data, valid while M_RE=1.
- ENGAGED  out  1  hold duty active.
- BUSY  out  1  not in IDLE and not in FAULT.
- FAULT  out  1  sequencer in FAULT state.
- FAULT_CODE  out  2  {over_curr, faultb_low} captured at fault detection.

## Operation
- States: IDLE, W_POL, W_PULL, W_EN, PULL_WAIT, W_HOLD, HOLD, POLL_RD, POLL_CHK, W_DIS, FAULT, W_CLR1, W_CLR2.
- Each W_* state lasts exactly one cycle and drives M_WE=1 with the given address and data. All other strobes are 0.
  - W_POL: addr 7, data {31'b0,POLARITY}.
  - W_PULL: addr 8, PULL_DUTY.
  - W_EN: addr 6, 1.
  - W_HOLD: addr 8, HOLD_DUTY.
  - W_DIS: addr 6, 0.
  - W_CLR1: addr 5, 1.
  - W_CLR2: addr 5, 0.
- IDLE -> W_POL on an ENGAGE rising edge (ENGAGE=1 and the registered previous value=0). A level held high across a fault does not re-engage.
- Engage path: W_POL -> W_PULL -> W_EN -> PULL_WAIT.
- PULL_WAIT:
  - 16-bit pull timer loads 0 in W_EN and increments every cycle, including during POLL_RD/POLL_CHK.
  - When timer >= PULL_TIME-1 in PULL_WAIT: -> W_HOLD -> HOLD.
  - Timer expiry is evaluated only in PULL_WAIT.
- Polling:
  - 16-bit poll counter runs in PULL_WAIT and HOLD.
  - At POLL_PERIOD-1 the counter clears and the FSM enters POLL_RD (M_RE=1, M_ADDR=5).
  - Then POLL_CHK samples M_DI[1:0], as registered at the end of POLL_RD.
  - A phase bit returns POLL_CHK to PULL_WAIT or HOLD.
- Fault: sampled bit1=1 (over-current) or bit0=0 (faultb latched low). FAULT_CODE <= {bit1, ~bit0}, then -> W_DIS -> FAULT.
- Release: ENGAGE=0 in PULL_WAIT, HOLD or POLL_CHK -> W_DIS -> IDLE.
- Simultaneous fault and release in POLL_CHK: fault wins, destination FAULT.
- FAULT: CLR_FAULT=1 -> W_CLR1 -> W_CLR2 -> IDLE, and FAULT_CODE clears in W_CLR2. CLR_FAULT is ignored in all other states.
- The controller faultb latch clears only on its own reset. A re-engage after clear with faultb still latched therefore faults again at the first poll; this is required behaviour.
- ENGAGE and CLR_FAULT are ignored inside W_* sequences, which always complete.
- ENGAGED=1 in W_HOLD+1 through HOLD/POLL_RD/POLL_CHK (hold phase). It is 0 elsewhere.

## Timing
- Reset (OPB_RSTb=0 at posedge):
  - State IDLE.
  - M_WE=M_RE=0, M_ADDR=0, M_DO=0.
  - ENGAGED=BUSY=FAULT=0, FAULT_CODE=0.
  - Timers=0, ENGAGE history=0.
- Reset mid-sequence aborts immediately. No disable write is issued; the controller is reset by the same system reset.
- All outputs are registered; strobes are driven from the posedge and held for one full cycle. The controller captures writes on the negedge, so write data is stable across it.
- Latencies:
  - ENGAGE rise to the W_POL strobe: 1 cycle after the edge is registered.
  - First W_EN strobe: 2 cycles after W_POL.
  - Detection (POLL_CHK) to W_DIS: 1 cycle.
  - Worst-case fault detection: POLL_PERIOD+2 cycles.
- No back-to-back strobes on different addresses overlap; WE and RE are never both 1.

## Test plan
- Reset then ENGAGE rise:
  - Writes appear in order (7,1), (8,0x258), (6,1) on consecutive cycles.
  - PULL_TIME later (±2), (8,0x12C) appears and ENGAGED=1.
- Hold with M_DI=0x1: reads of addr 5 occur every POLL_PERIOD cycles (±2) and there are no writes.
- Hold with M_DI=0x3 at a poll: W_DIS (6,0) follows, then FAULT=1 and FAULT_CODE=2'b10. ENGAGE held high causes no re-engage.
- M_DI=0x0 during PULL_WAIT: fault with FAULT_CODE=2'b01. CLR_FAULT then produces (5,1),(5,0) and IDLE; a new ENGAGE rise faults again at the first poll.
- ENGAGE drop in HOLD: (6,0) is issued, then IDLE with BUSY=0. ENGAGE drop and fault in the same POLL_CHK end in FAULT.
- OPB_RSTb low mid-W_PULL: the next cycle has all outputs 0 and state IDLE, and no further strobes occur.

Source files
------------

// File: rtl/brake_seq_if.sv
// rtl/brake_seq_if.sv - OPB master-side bus bundle between brake_seq and the brake PWM controller.
interface brake_seq_if;
  logic [3:0]  M_ADDR;
  logic [31:0] M_DO;
  logic        M_WE;
  logic        M_RE;
  logic [31:0] M_DI;

  modport master (
    output M_ADDR,
    output M_DO,
    output M_WE,
    output M_RE,
    input  M_DI
  );

  modport slave (
    input  M_ADDR,
    input  M_DO,
    input  M_WE,
    input  M_RE,
    output M_DI
  );
endinterface

// File: rtl/brake_seq.sv
// rtl/brake_seq.sv - brake engage/hold sequencer driving the PWM controller over OPB.
module brake_seq #(
  parameter logic [31:0] PULL_DUTY   = 32'h258,
  parameter logic [31:0] HOLD_DUTY   = 32'h12C,
  parameter logic        POLARITY    = 1'b1,
  parameter logic [15:0] PULL_TIME   = 16'd32000,
  parameter logic [15:0] POLL_PERIOD = 16'd320
) (
  input  logic        OPB_CLK,
  input  logic        OPB_RSTb,
  brake_seq_if.master bus,
  input  logic        ENGAGE,
  input  logic        CLR_FAULT,
  output logic        ENGAGED,
  output logic        BUSY,
  output logic        FAULT,
  output logic [1:0]  FAULT_CODE
);

  localparam logic [3:0] ADDR_FAULT  = 4'd5;
  localparam logic [3:0] ADDR_ENABLE = 4'd6;
  localparam logic [3:0] ADDR_POL    = 4'd7;
  localparam logic [3:0] ADDR_CYCLE  = 4'd8;

  typedef enum logic [3:0] {
    IDLE, W_POL, W_PULL, W_EN, PULL_WAIT, W_HOLD, HOLD,
    POLL_RD, POLL_CHK, W_DIS, FAULT_ST, W_CLR1, W_CLR2
  } state_t;

  state_t      state_q, state_d;
  logic        eng_prev_q;
  logic [15:0] pull_tmr_q;
  logic [15:0] poll_cnt_q;
  logic [1:0]  di_q;
  logic        hold_phase_q;
  logic        fault_pend_q;
  logic [1:0]  fault_code_q;

  logic        we_q, re_q, engaged_q, busy_q, fault_q;
  logic [3:0]  addr_q;
  logic [31:0] do_q;
  logic        we_d, re_d, engaged_d;
  logic [3:0]  addr_d;
  logic [31:0] do_d;

  logic        eng_rise, poll_hit, pull_done, fault_seen;
  logic        unused_di;

  assign eng_rise   = ENGAGE & ~eng_prev_q;
  assign poll_hit   = (poll_cnt_q == POLL_PERIOD - 16'd1);
  assign pull_done  = (pull_tmr_q >= PULL_TIME - 16'd1);
  assign fault_seen = di_q[1] | ~di_q[0];
  assign unused_di  = ^bus.M_DI[31:2];

  // Release is checked before polling, and polling before pull expiry; the
  // >= compare lets expiry be taken on the first PULL_WAIT cycle after a poll.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (eng_rise) state_d = W_POL;
      W_POL:     state_d = W_PULL;
      W_PULL:    state_d = W_EN;
      W_EN:      state_d = PULL_WAIT;
      PULL_WAIT: begin
        if (!ENGAGE)        state_d = W_DIS;
        else if (poll_hit)  state_d = POLL_RD;
        else if (pull_done) state_d = W_HOLD;
      end
      W_HOLD:    state_d = HOLD;
      HOLD: begin
        if (!ENGAGE)       state_d = W_DIS;
        else if (poll_hit) state_d = POLL_RD;
      end
      POLL_RD:   state_d = POLL_CHK;
      POLL_CHK: begin
        if (fault_seen || !ENGAGE) state_d = W_DIS;
        else if (hold_phase_q)     state_d = HOLD;
        else                       state_d = PULL_WAIT;
      end
      W_DIS:     state_d = fault_pend_q ? FAULT_ST : IDLE;
      FAULT_ST:  if (CLR_FAULT) state_d = W_CLR1;
      W_CLR1:    state_d = W_CLR2;
      W_CLR2:    state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    we_d   = 1'b0;
    re_d   = 1'b0;
    addr_d = 4'd0;
    do_d   = 32'd0;
    case (state_d)
      W_POL:   begin we_d = 1'b1; addr_d = ADDR_POL;    do_d = {31'd0, POLARITY}; end
      W_PULL:  begin we_d = 1'b1; addr_d = ADDR_CYCLE;  do_d = PULL_DUTY;         end
      W_EN:    begin we_d = 1'b1; addr_d = ADDR_ENABLE; do_d = 32'd1;             end
      W_HOLD:  begin we_d = 1'b1; addr_d = ADDR_CYCLE;  do_d = HOLD_DUTY;         end
      W_DIS:   begin we_d = 1'b1; addr_d = ADDR_ENABLE; do_d = 32'd0;             end
      W_CLR1:  begin we_d = 1'b1; addr_d = ADDR_FAULT;  do_d = 32'd1;             end
      W_CLR2:  begin we_d = 1'b1; addr_d = ADDR_FAULT;  do_d = 32'd0;             end
      POLL_RD: begin re_d = 1'b1; addr_d = ADDR_FAULT;                            end
      default: ;
    endcase
    engaged_d = (state_d == HOLD) ||
                (((state_d == POLL_RD) || (state_d == POLL_CHK)) && hold_phase_q);
  end

  always_ff @(posedge OPB_CLK) begin
    if (!OPB_RSTb) begin
      state_q      <= IDLE;
      eng_prev_q   <= 1'b0;
      pull_tmr_q   <= 16'd0;
      poll_cnt_q   <= 16'd0;
      di_q         <= 2'b01;
      hold_phase_q <= 1'b0;
      fault_pend_q <= 1'b0;
      fault_code_q <= 2'b00;
      we_q         <= 1'b0;
      re_q         <= 1'b0;
      addr_q       <= 4'd0;
      do_q         <= 32'd0;
      engaged_q    <= 1'b0;
      busy_q       <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      eng_prev_q <= ENGAGE;

      if (state_q == W_EN) begin
        pull_tmr_q <= 16'd0;
      end else if ((state_q == PULL_WAIT || state_q == POLL_RD || state_q == POLL_CHK) &&
                   (pull_tmr_q != 16'hFFFF)) begin
        pull_tmr_q <= pull_tmr_q + 16'd1;
      end

      if (state_q == W_EN) begin
        poll_cnt_q <= 16'd0;
      end else if (state_q == PULL_WAIT || state_q == HOLD) begin
        poll_cnt_q <= poll_hit ? 16'd0 : poll_cnt_q + 16'd1;
      end

      if (state_q == POLL_RD) di_q <= bus.M_DI[1:0];

      if (state_q == W_EN)        hold_phase_q <= 1'b0;
      else if (state_q == W_HOLD) hold_phase_q <= 1'b1;

      // Fault outranks a simultaneous release, so W_DIS knows where to go.
      if (state_q == POLL_CHK && fault_seen) begin
        fault_pend_q <= 1'b1;
        fault_code_q <= {di_q[1], ~di_q[0]};
      end else if (state_q == W_DIS) begin
        fault_pend_q <= 1'b0;
      end
      if (state_d == W_CLR2) fault_code_q <= 2'b00;

      we_q      <= we_d;
      re_q      <= re_d;
      addr_q    <= addr_d;
      do_q      <= do_d;
      engaged_q <= engaged_d;
      busy_q    <= (state_d != IDLE) && (state_d != FAULT_ST);
      fault_q   <= (state_d == FAULT_ST);
    end
  end

  assign bus.M_WE   = we_q;
  assign bus.M_RE   = re_q;
  assign bus.M_ADDR = addr_q;
  assign bus.M_DO   = do_q;
  assign ENGAGED    = engaged_q;
  assign BUSY       = busy_q;
  assign FAULT      = fault_q;
  assign FAULT_CODE = fault_code_q;

endmodule
